// File: rtl/md_pkg.sv
// Shared definitions for the multicycle multiply/divide engine.
// State and operation encodings plus the default operand width.
package md_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MULT    = 3'd1,
        ST_DIV     = 3'd2,
        ST_DIV_FIX = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

endpackage

// File: rtl/md_addsub.sv
// Combinational W-bit adder/subtractor with carry-out.
// With sub=1 the carry-out is the "no borrow" flag (x >= y, unsigned).
module md_addsub #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] y_eff;

    always_comb begin
        y_eff       = sub ? ~y : y;
        {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, sub};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV engine owning HI/LO; one shared add/sub path
// is stepped through WIDTH Booth or restoring-division iterations.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state;
    logic [CNT_W-1:0] count;

    // Working registers, shared by both operations:
    // mult: work_hi = accumulator, work_lo = multiplier, opnd = multiplicand
    // div:  work_hi = remainder,   work_lo = dividend/quotient, opnd = divisor
    logic [WIDTH:0]   work_hi;
    logic [WIDTH-1:0] work_lo;
    logic             work_q1;
    logic [WIDTH-1:0] opnd;
    logic             quo_neg;
    logic             rem_neg;

    op_t              op_sel;
    logic [WIDTH:0]   as_x;
    logic [WIDTH:0]   as_y;
    logic             as_sub;
    logic [WIDTH:0]   as_sum;
    logic             as_cout;

    logic [WIDTH:0]   booth_hi;
    logic [WIDTH:0]   mult_hi_n;
    logic [WIDTH-1:0] mult_lo_n;
    logic [WIDTH-1:0] div_rem_n;
    logic [WIDTH-1:0] div_quo_n;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             last;

    md_addsub #(
        .W (WIDTH + 1)
    ) u_addsub (
        .x    (as_x),
        .y    (as_y),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    always_comb begin
        op_sel = (state == ST_DIV) ? OP_DIV : OP_MULT;
        as_x   = work_hi;
        as_y   = {opnd[WIDTH-1], opnd};
        as_sub = work_lo[0] & ~work_q1;
        if (op_sel == OP_DIV) begin
            as_x   = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
            as_y   = {1'b0, opnd};
            as_sub = 1'b1;
        end

        // Booth pair 01 adds, 10 subtracts, 00/11 only shift.
        booth_hi  = (work_lo[0] ^ work_q1) ? as_sum : work_hi;
        mult_hi_n = {booth_hi[WIDTH], booth_hi[WIDTH:1]};
        mult_lo_n = {booth_hi[0], work_lo[WIDTH-1:1]};

        // Partial remainder is always below the divisor, so WIDTH bits suffice.
        div_rem_n = as_cout ? as_sum[WIDTH-1:0] : as_x[WIDTH-1:0];
        div_quo_n = {work_lo[WIDTH-2:0], as_cout};

        abs_a = a[WIDTH-1] ? -a : a;
        abs_b = b[WIDTH-1] ? -b : b;
        last  = (count == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            work_q1  <= 1'b0;
            opnd     <= '0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_mult) begin
                        state   <= ST_MULT;
                        busy    <= 1'b1;
                        count   <= '0;
                        work_hi <= '0;
                        work_lo <= b;
                        work_q1 <= 1'b0;
                        opnd    <= a;
                    end else if (start_div) begin
                        if (b == '0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state   <= ST_DIV;
                            busy    <= 1'b1;
                            count   <= '0;
                            work_hi <= '0;
                            work_lo <= abs_a;
                            work_q1 <= 1'b0;
                            opnd    <= abs_b;
                            quo_neg <= a[WIDTH-1] ^ b[WIDTH-1];
                            rem_neg <= a[WIDTH-1];
                        end
                    end
                end
                ST_MULT: begin
                    work_hi <= mult_hi_n;
                    work_lo <= mult_lo_n;
                    work_q1 <= work_lo[0];
                    count   <= count + 1'b1;
                    if (last) begin
                        hi    <= mult_hi_n[WIDTH-1:0];
                        lo    <= mult_lo_n;
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end
                end
                ST_DIV: begin
                    work_hi <= {1'b0, div_rem_n};
                    work_lo <= div_quo_n;
                    count   <= count + 1'b1;
                    if (last) begin
                        state <= ST_DIV_FIX;
                    end
                end
                ST_DIV_FIX: begin
                    lo    <= quo_neg ? -work_lo : work_lo;
                    hi    <= rem_neg ? -work_hi[WIDTH-1:0] : work_hi[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= ST_FINISH;
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed MULT/DIV engine, sequenced by the main control unit.
- Owns HI/LO and sequences one shared 33-bit add/sub path through WIDTH iterations.
- Control unit pulses a start signal, holds in a wait state while busy is high, then samples done/div_zero.
- HI/LO feed the MEMtoReg write-back mux for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_mult  in  1  1-cycle request: signed multiply a*b
- start_div  in  1  1-cycle request: signed divide a/b
- a  in  WIDTH  operand A (rs); sampled only with an accepted start
- b  in  WIDTH  operand B (rt); sampled only with an accepted start
- busy  out  1  operation in progress
- done  out  1  1-cycle pulse; HI/LO new values valid in the same cycle
- div_zero  out  1  1-cycle pulse; divide by zero detected
- hi  out  WIDTH  HI register (product high half / remainder)
- lo  out  WIDTH  LO register (product low half / quotient)

Behaviour:
- All outputs registered. Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0, state=IDLE, counter=0.
- State machine: IDLE, MULT, DIV, DIV_FIX, FINISH.
- Starts are accepted only in IDLE; a start while busy is ignored, with no queuing.
- Cycle numbering: an accepted start is high in cycle 0.
- IDLE: start_mult -> MULT. start_div with b!=0 -> DIV. start_div with b==0 -> IDLE.
  - If start_mult and start_div are both high, multiply wins.
  - On entry, operands are latched and counter=0.
- MULT, radix-2 Booth on {acc, multiplier, q-1}:
  - One add/sub plus an arithmetic right shift per cycle.
  - Runs cycles 1..WIDTH, then FINISH.
  - Result is the full 2*WIDTH signed product: hi = upper half, lo = lower half.
- DIV, restoring division on absolute values:
  - One trial subtract/shift per cycle over cycles 1..WIDTH, then DIV_FIX in cycle WIDTH+1.
  - DIV_FIX negates the quotient if the operand signs differ, and negates the remainder if a<0, then goes to FINISH.
  - Quotient truncates toward zero and goes to lo; remainder takes the sign of the dividend and goes to hi.
  - -2^(WIDTH-1) / -1: lo=0x80000000, hi=0 (wraps, no flag).
- FINISH: hi/lo are written on the edge entering FINISH; done=1 for exactly one cycle; then IDLE.
- Latency to done: mult = WIDTH+1 cycles after start (cycle 33). Div = WIDTH+2 cycles after start (cycle 34).
- busy: high from cycle 1 through the done cycle inclusive; low in IDLE.
- Divide by zero:
  - No iteration is performed.
  - div_zero=1 and done=1 together in cycle 1.
  - busy stays 0; hi/lo are unchanged.
- hi/lo hold their values between operations and are never modified mid-iteration; working registers are separate.
- Reset mid-operation: abort on the next edge, return to IDLE, all outputs reset (hi=lo=0), no done pulse.

Decomposition:
- Shared package md_pkg:
  - state encoding constants ST_IDLE/ST_MULT/ST_DIV/ST_DIV_FIX/ST_FINISH;
  - op select constants OP_MULT/OP_DIV;
  - WIDTH default.
- One natural sub-module: md_addsub, a combinational WIDTH+1-bit adder/subtractor with carry-out.
  - Shared by the Booth step and the restoring trial subtract.
  - Inputs: x, y, sub. Outputs: sum, cout.

Test Plan:
- start_mult, a=7, b=-3 (0xFFFFFFFD) -> done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1..33.
- start_mult, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- start_div, a=-7, b=2 -> done in cycle 34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then a=100, b=7 -> lo=14, hi=2.
- start_div, a=5, b=0 -> cycle 1: div_zero=1, done=1, busy=0; hi/lo keep the previous values. Then a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- start_mult at cycle 0, then start_div at cycle 5 and at cycle 20 -> both ignored; single done at cycle 33 with the mult result. start_mult+start_div together -> multiply performed.
- Reset asserted at cycle 10 of a divide -> cycle 11: busy=0, hi=lo=0, no done; a new start_mult at cycle 12 completes normally at cycle 45.
